// File: rtl/cache_pkg.sv
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and constants for the write-back line cache:
//                controller state encoding, word/byte geometry and the bit
//                layout of a tag RAM word.
//  Revision    : 1.0 - initial write-back release
// ============================================================================
`default_nettype none

package cache_pkg;

  // Controller states; the explicit width keeps the encoding stable.
  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_LOOKUP     = 3'd2,
    ST_EVICT_CMD  = 3'd3,
    ST_EVICT_DATA = 3'd4,
    ST_FILL_CMD   = 3'd5,
    ST_FILL_DATA  = 3'd6,
    ST_REPLAY     = 3'd7
  } cache_state_e;

  // Bytes per 32-bit word and the matching number of byte-offset bits.
  localparam int WORD_BYTES     = 4;
  localparam int ZEROS_BITWIDTH = 2;

  // Tag word layout: {tag, dirty, valid}.
  localparam int TAG_VALID_POS  = 0;
  localparam int TAG_DIRTY_POS  = 1;
  localparam int TAG_FLAG_BITS  = 2;

endpackage

`default_nettype wire

// File: rtl/cache_writeback_if.sv
// ============================================================================
//  Module      : cache_writeback_if
//  Description : CPU request/response and burst memory signals of the
//                write-back cache. 'slave' is the cache view, 'master' is the
//                environment (CPU + RAM controller) view.
//  Revision    : 1.0 - initial write-back release
// ============================================================================
`default_nettype none

interface cache_writeback_if
  import cache_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH = 32
);

  // CPU side
  logic                        req_valid;
  logic                        req_ready;
  logic [ADDRESS_BITWIDTH-1:0] req_address;
  logic [WORD_BYTES-1:0]       req_write_strobe;
  logic [31:0]                 req_data;
  logic                        rsp_valid;
  logic [31:0]                 rsp_data;

  // Memory side
  logic                        mem_cmd_valid;
  logic                        mem_cmd_ready;
  logic                        mem_cmd_write;
  logic [ADDRESS_BITWIDTH-1:0] mem_cmd_address;
  logic [31:0]                 mem_wdata;
  logic                        mem_wdata_valid;
  logic                        mem_wdata_ready;
  logic [31:0]                 mem_rdata;
  logic                        mem_rdata_valid;

  modport slave (
    input  req_valid, req_address, req_write_strobe, req_data,
    output req_ready, rsp_valid, rsp_data,
    output mem_cmd_valid, mem_cmd_write, mem_cmd_address,
    output mem_wdata, mem_wdata_valid,
    input  mem_cmd_ready, mem_wdata_ready, mem_rdata, mem_rdata_valid
  );

  modport master (
    output req_valid, req_address, req_write_strobe, req_data,
    input  req_ready, rsp_valid, rsp_data,
    input  mem_cmd_valid, mem_cmd_write, mem_cmd_address,
    input  mem_wdata, mem_wdata_valid,
    output mem_cmd_ready, mem_wdata_ready, mem_rdata, mem_rdata_valid
  );

endinterface

`default_nettype wire

// File: rtl/cache_line_ram.sv
// ============================================================================
//  Module      : cache_line_ram
//  Description : Data store of the cache. One byte-enabled single-port BRAM
//                per column; all columns are read in parallel at the shared
//                line address, and a column-select decode steers writes.
//  Revision    : 1.0 - initial write-back release
// ============================================================================
`default_nettype none

module cache_line_ram
  import cache_pkg::*;
#(
  parameter int LINE_IX_BITWIDTH   = 8,
  parameter int COLUMN_IX_BITWIDTH = 2
) (
  input  logic                                     clk,
  input  logic [LINE_IX_BITWIDTH-1:0]              addr,
  input  logic                                     wr_en,
  input  logic [COLUMN_IX_BITWIDTH-1:0]            wr_column,
  input  logic [WORD_BYTES-1:0]                    wr_strobe,
  input  logic [31:0]                              wr_data,
  output logic [(2**COLUMN_IX_BITWIDTH)-1:0][31:0] rd_data
);

  localparam int COLUMN_COUNT = 2**COLUMN_IX_BITWIDTH;
  localparam int LINE_COUNT   = 2**LINE_IX_BITWIDTH;

  for (genvar c = 0; c < COLUMN_COUNT; c++) begin : g_column
    logic [31:0] mem_q [LINE_COUNT];
    logic [31:0] rd_q;
    logic        column_we;

    assign column_we = wr_en && (wr_column == COLUMN_IX_BITWIDTH'(c));

    // Byte-enabled write with read-old-data synchronous read.
    always_ff @(posedge clk) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (column_we && wr_strobe[b]) begin
          mem_q[addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      rd_q <= mem_q[addr];
    end

    assign rd_data[c] = rd_q;
  end

endmodule

`default_nettype wire

// File: rtl/cache_writeback.sv
// ============================================================================
//  Module      : cache_writeback
//  Description : Direct-mapped, write-back, write-allocate data cache with
//                per-line dirty tracking, byte-strobe writes, burst
//                eviction/fill and a post-reset tag-clear sweep.
//                Optional feature macro: CACHE_STATS_EN (hit/miss counters).
//  Revision    : 1.0 - initial write-back release
// ============================================================================
`default_nettype none

module cache_writeback
  import cache_pkg::*;
#(
  parameter int LINE_IX_BITWIDTH   = 8,
  parameter int COLUMN_IX_BITWIDTH = 2,
  parameter int ADDRESS_BITWIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  cache_writeback_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses
`endif
);

  localparam int TAG_BITWIDTH      = ADDRESS_BITWIDTH - LINE_IX_BITWIDTH
                                     - COLUMN_IX_BITWIDTH - ZEROS_BITWIDTH;
  localparam int LINE_COUNT        = 2**LINE_IX_BITWIDTH;
  localparam int COLUMN_COUNT      = 2**COLUMN_IX_BITWIDTH;
  localparam int TAG_WORD_BITWIDTH = TAG_BITWIDTH + TAG_FLAG_BITS;
  localparam int COLUMN_LSB        = ZEROS_BITWIDTH;
  localparam int LINE_LSB          = COLUMN_LSB + COLUMN_IX_BITWIDTH;
  localparam int TAG_LSB           = LINE_LSB + LINE_IX_BITWIDTH;

  // Registered request and controller state
  cache_state_e                  state_q, state_d;
  logic [LINE_IX_BITWIDTH-1:0]   init_q, init_d;
  logic [LINE_IX_BITWIDTH-1:0]   line_q, line_d;
  logic [COLUMN_IX_BITWIDTH-1:0] col_q, col_d;
  logic [TAG_BITWIDTH-1:0]       tag_q, tag_d;
  logic [TAG_BITWIDTH-1:0]       old_tag_q, old_tag_d;
  logic [WORD_BYTES-1:0]         strobe_q, strobe_d;
  logic [31:0]                   data_q, data_d;
  logic [COLUMN_IX_BITWIDTH-1:0] beat_q, beat_d;

  // Request address fields
  logic [COLUMN_IX_BITWIDTH-1:0] req_col;
  logic [LINE_IX_BITWIDTH-1:0]   req_line;
  logic [TAG_BITWIDTH-1:0]       req_tag;
  logic [ZEROS_BITWIDTH-1:0]     unused_byte_offset;

  assign req_col            = bus.req_address[COLUMN_LSB +: COLUMN_IX_BITWIDTH];
  assign req_line           = bus.req_address[LINE_LSB +: LINE_IX_BITWIDTH];
  assign req_tag            = bus.req_address[TAG_LSB +: TAG_BITWIDTH];
  assign unused_byte_offset = bus.req_address[ZEROS_BITWIDTH-1:0];

  // Shared RAM port controls
  logic [LINE_IX_BITWIDTH-1:0]       ram_addr;
  logic                              data_we;
  logic [COLUMN_IX_BITWIDTH-1:0]     data_col;
  logic [WORD_BYTES-1:0]             data_strobe;
  logic [31:0]                       data_wdata;
  logic [COLUMN_COUNT-1:0][31:0]     line_rdata;
  logic                              tag_we;
  logic [TAG_WORD_BITWIDTH-1:0]      tag_wdata;

  // Tag memory (one {tag, dirty, valid} word per line)
  logic [TAG_WORD_BITWIDTH-1:0] tag_mem_q [LINE_COUNT];
  logic [TAG_WORD_BITWIDTH-1:0] tag_rdata_q;

  // Tag RAM: single port, synchronous read of old data on a write cycle.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem_q[ram_addr] <= tag_wdata;
    end
    tag_rdata_q <= tag_mem_q[ram_addr];
  end

  cache_line_ram #(
    .LINE_IX_BITWIDTH  (LINE_IX_BITWIDTH),
    .COLUMN_IX_BITWIDTH(COLUMN_IX_BITWIDTH)
  ) u_line_ram (
    .clk      (clk),
    .addr     (ram_addr),
    .wr_en    (data_we),
    .wr_column(data_col),
    .wr_strobe(data_strobe),
    .wr_data  (data_wdata),
    .rd_data  (line_rdata)
  );

  // Lookup decode of the tag word read for the current line
  logic [TAG_BITWIDTH-1:0] stored_tag;
  logic                    stored_valid;
  logic                    stored_dirty;
  logic                    lookup_hit;
  logic [31:0]             lookup_word;

  assign stored_tag   = tag_rdata_q[TAG_WORD_BITWIDTH-1:TAG_FLAG_BITS];
  assign stored_valid = tag_rdata_q[TAG_VALID_POS];
  assign stored_dirty = tag_rdata_q[TAG_DIRTY_POS];
  assign lookup_hit   = stored_valid && (stored_tag == tag_q);
  assign lookup_word  = line_rdata[col_q];

  // Next-state, RAM controls and all bus outputs; defaults first.
  always_comb begin
    state_d   = state_q;
    init_d    = init_q;
    line_d    = line_q;
    col_d     = col_q;
    tag_d     = tag_q;
    old_tag_d = old_tag_q;
    strobe_d  = strobe_q;
    data_d    = data_q;
    beat_d    = beat_q;

    ram_addr    = line_q;
    data_we     = 1'b0;
    data_col    = col_q;
    data_strobe = strobe_q;
    data_wdata  = data_q;
    tag_we      = 1'b0;
    tag_wdata   = '0;

    bus.req_ready       = 1'b0;
    bus.rsp_valid       = 1'b0;
    bus.rsp_data        = '0;
    bus.mem_cmd_valid   = 1'b0;
    bus.mem_cmd_write   = 1'b0;
    bus.mem_cmd_address = '0;
    bus.mem_wdata       = '0;
    bus.mem_wdata_valid = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        // Clear one tag word per cycle; the counter wraps back to 0.
        ram_addr = init_q;
        tag_we   = 1'b1;
        init_d   = init_q + 1'b1;
        if (&init_q) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        bus.req_ready = 1'b1;
        // Present the incoming line index so both RAMs are read for LOOKUP.
        ram_addr = req_line;
        if (bus.req_valid) begin
          line_d   = req_line;
          col_d    = req_col;
          tag_d    = req_tag;
          strobe_d = bus.req_write_strobe;
          data_d   = bus.req_data;
          state_d  = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (lookup_hit) begin
          bus.rsp_valid = 1'b1;
          if (strobe_q == '0) begin
            bus.rsp_data = lookup_word;
          end else begin
            data_we   = 1'b1;
            tag_we    = 1'b1;
            tag_wdata = {tag_q, 1'b1, 1'b1};
          end
          state_d = ST_IDLE;
        end else begin
          old_tag_d = stored_tag;
          beat_d    = '0;
          state_d   = (stored_valid && stored_dirty) ? ST_EVICT_CMD : ST_FILL_CMD;
        end
      end

      ST_EVICT_CMD: begin
        bus.mem_cmd_valid   = 1'b1;
        bus.mem_cmd_write   = 1'b1;
        bus.mem_cmd_address = {old_tag_q, line_q,
                               {COLUMN_IX_BITWIDTH{1'b0}}, {ZEROS_BITWIDTH{1'b0}}};
        beat_d = '0;
        if (bus.mem_cmd_ready) begin
          state_d = ST_EVICT_DATA;
        end
      end

      ST_EVICT_DATA: begin
        // All columns are read every cycle, so the next beat is always ready.
        bus.mem_wdata_valid = 1'b1;
        bus.mem_wdata       = line_rdata[beat_q];
        if (bus.mem_wdata_ready) begin
          beat_d = beat_q + 1'b1;
          if (&beat_q) begin
            state_d = ST_FILL_CMD;
          end
        end
      end

      ST_FILL_CMD: begin
        bus.mem_cmd_valid   = 1'b1;
        bus.mem_cmd_address = {tag_q, line_q,
                               {COLUMN_IX_BITWIDTH{1'b0}}, {ZEROS_BITWIDTH{1'b0}}};
        beat_d = '0;
        if (bus.mem_cmd_ready) begin
          state_d = ST_FILL_DATA;
        end
      end

      ST_FILL_DATA: begin
        if (bus.mem_rdata_valid) begin
          data_we     = 1'b1;
          data_col    = beat_q;
          data_strobe = '1;
          data_wdata  = bus.mem_rdata;
          beat_d      = beat_q + 1'b1;
          if (&beat_q) begin
            tag_we    = 1'b1;
            tag_wdata = {tag_q, 1'b0, 1'b1};
            state_d   = ST_REPLAY;
          end
        end
      end

      ST_REPLAY: begin
        // ram_addr already defaults to line_q: re-read the freshly filled line.
        state_d = ST_LOOKUP;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Controller and request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      init_q    <= '0;
      line_q    <= '0;
      col_q     <= '0;
      tag_q     <= '0;
      old_tag_q <= '0;
      strobe_q  <= '0;
      data_q    <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      line_q    <= line_d;
      col_q     <= col_d;
      tag_q     <= tag_d;
      old_tag_q <= old_tag_d;
      strobe_q  <= strobe_d;
      data_q    <= data_d;
      beat_q    <= beat_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_misses_q, stat_misses_d;
  logic        replay_q, replay_d;

  // Count only the first lookup of each request; both counters saturate.
  always_comb begin
    stat_hits_d   = stat_hits_q;
    stat_misses_d = stat_misses_q;
    replay_d      = replay_q;
    if (state_q == ST_IDLE) begin
      replay_d = 1'b0;
    end else if (state_q == ST_REPLAY) begin
      replay_d = 1'b1;
    end
    if (state_q == ST_LOOKUP && !replay_q) begin
      if (lookup_hit) begin
        if (stat_hits_q != 32'hFFFF_FFFF) begin
          stat_hits_d = stat_hits_q + 32'd1;
        end
      end else if (stat_misses_q != 32'hFFFF_FFFF) begin
        stat_misses_d = stat_misses_q + 32'd1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
      replay_q      <= 1'b0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_misses_q <= stat_misses_d;
      replay_q      <= replay_d;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_writeback.sv
// ============================================================================
//  Module      : tb_cache_writeback
//  Description : Directed self-checking bench for cache_writeback: init sweep,
//                fill, hit, strobed write, dirty eviction with back-pressure,
//                reset during a fill and (with CACHE_STATS_EN) the counters.
//  Revision    : 1.0 - initial write-back release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cache_writeback;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_writeback_if #(.ADDRESS_BITWIDTH(32)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  cache_writeback #(
    .LINE_IX_BITWIDTH  (8),
    .COLUMN_IX_BITWIDTH(2),
    .ADDRESS_BITWIDTH  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout expected event within bound", tag);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request and return at the negedge after it was accepted.
  task automatic issue(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
    int n;
    bus.req_valid        = 1'b1;
    bus.req_address      = addr;
    bus.req_write_strobe = strb;
    bus.req_data         = data;
    n = 0;
    while (!bus.req_ready && n < 400) begin
      step();
      n++;
    end
    if (!bus.req_ready) timeout("issue");
    step();
    bus.req_valid = 1'b0;
  endtask

  // Wait for a command, check it, and let it handshake (mem_cmd_ready is 1).
  task automatic wait_cmd(input string tag, input logic wr, input logic [31:0] addr);
    int n;
    n = 0;
    while (!bus.mem_cmd_valid && n < 20) begin
      step();
      n++;
    end
    if (!bus.mem_cmd_valid) timeout(tag);
    chk({tag, "_write"}, 32'(bus.mem_cmd_write), 32'(wr));
    chk({tag, "_addr"}, bus.mem_cmd_address, addr);
    step();
    chk({tag, "_dropped"}, 32'(bus.mem_cmd_valid), 32'd0);
  endtask

  // Four fill beats, beat i = {4{base+i}}, optionally with idle gaps.
  task automatic fill(input logic [7:0] base, input bit gap);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = base + 8'(i);
      bus.mem_rdata       = {4{b}};
      bus.mem_rdata_valid = 1'b1;
      step();
      bus.mem_rdata_valid = 1'b0;
      if (gap) step();
    end
  endtask

  // Wait for the response pulse, check data and that it lasts one cycle.
  task automatic wait_rsp(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      step();
      n++;
    end
    if (!bus.rsp_valid) timeout(tag);
    chk({tag, "_data"}, bus.rsp_data, exp);
    step();
    chk({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
    chk({tag, "_cmd_valid"}, 32'(bus.mem_cmd_valid), 32'd0);
    chk({tag, "_cmd_write"}, 32'(bus.mem_cmd_write), 32'd0);
    chk({tag, "_cmd_addr"}, bus.mem_cmd_address, 32'd0);
    chk({tag, "_wdata_valid"}, 32'(bus.mem_wdata_valid), 32'd0);
`ifdef CACHE_STATS_EN
    chk({tag, "_stat_hits"}, stat_hits, 32'd0);
    chk({tag, "_stat_misses"}, stat_misses, 32'd0);
`endif
  endtask

  // Release reset with req_valid held and count cycles until req_ready.
  task automatic init_sweep(input string tag);
    int cnt;
    rst = 1'b0;
    cnt = 0;
    while (!bus.req_ready && cnt < 400) begin
      step();
      cnt++;
    end
    chk(tag, 32'(cnt), 32'd256);
  endtask

  logic [31:0] evict_exp [4];

  initial begin
    bus.req_valid        = 1'b0;
    bus.req_address      = '0;
    bus.req_write_strobe = '0;
    bus.req_data         = '0;
    bus.mem_cmd_ready    = 1'b1;
    bus.mem_wdata_ready  = 1'b1;
    bus.mem_rdata        = '0;
    bus.mem_rdata_valid  = 1'b0;
    evict_exp = '{32'hA0A0A0A0, 32'hA1A1BEEF, 32'hA2A2A2A2, 32'hA3A3A3A3};

    // Reset state
    step();
    step();
    check_reset_outputs("reset");

    // Init sweep holds off a pending read of 0x100, which then misses
    bus.req_valid   = 1'b1;
    bus.req_address = 32'h100;
    init_sweep("init_cycles");
    step();
    bus.req_valid = 1'b0;
    chk("miss_0x100_no_rsp", 32'(bus.rsp_valid), 32'd0);
    wait_cmd("fill_0x100", 1'b0, 32'h100);
    fill(8'hB0, 1'b0);
    wait_rsp("rd_0x100", 32'hB0B0B0B0);

    // Stray fill beats outside FILL_DATA are ignored; fill line 0 with gaps
    bus.mem_rdata       = 32'hFFFF_FFFF;
    bus.mem_rdata_valid = 1'b1;
    step();
    issue(32'h0, 4'b0000, 32'h0);
    bus.mem_rdata_valid = 1'b0;
    wait_cmd("fill_0x0", 1'b0, 32'h0);
    fill(8'hA0, 1'b1);
    wait_rsp("rd_0x0", 32'hA0A0A0A0);

    // Read hit: response one cycle after acceptance, no memory traffic
    issue(32'h8, 4'b0000, 32'h0);
    chk("hit_0x8_valid", 32'(bus.rsp_valid), 32'd1);
    chk("hit_0x8_data", bus.rsp_data, 32'hA2A2A2A2);
    chk("hit_0x8_no_cmd", 32'(bus.mem_cmd_valid), 32'd0);
    step();
    chk("hit_0x8_pulse", 32'(bus.rsp_valid), 32'd0);
    chk("hit_0x8_no_cmd2", 32'(bus.mem_cmd_valid), 32'd0);

    // Strobed write hit, then read back the merged word
    issue(32'h4, 4'b0011, 32'hDEADBEEF);
    chk("wr_0x4_done", 32'(bus.rsp_valid), 32'd1);
    step();
    chk("wr_0x4_pulse", 32'(bus.rsp_valid), 32'd0);
    issue(32'h4, 4'b0000, 32'h0);
    chk("rd_0x4_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rd_0x4_data", bus.rsp_data, 32'hA1A1BEEF);
    step();

    // Dirty conflict miss: writeback of line 0 with a 3-cycle stall, then fill
    bus.mem_wdata_ready = 1'b0;
    issue(32'h4000, 4'b0000, 32'h0);
    wait_cmd("evict", 1'b1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("evict_stall_valid", 32'(bus.mem_wdata_valid), 32'd1);
      chk("evict_stall_data", bus.mem_wdata, evict_exp[0]);
      step();
    end
    bus.mem_wdata_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("evict_beat_valid", 32'(bus.mem_wdata_valid), 32'd1);
      chk("evict_beat_data", bus.mem_wdata, evict_exp[i]);
      step();
    end
    chk("evict_done", 32'(bus.mem_wdata_valid), 32'd0);
    wait_cmd("fill_0x4000", 1'b0, 32'h4000);
    fill(8'hC0, 1'b0);
    wait_rsp("rd_0x4000", 32'hC0C0C0C0);

    // Reset while beat 2 of a fill is on the bus
    issue(32'h0, 4'b0000, 32'h0);
    wait_cmd("fill_0x0_b", 1'b0, 32'h0);
    bus.mem_rdata       = 32'h5555_5555;
    bus.mem_rdata_valid = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    check_reset_outputs("midfill_reset");
    step();
    bus.mem_rdata_valid = 1'b0;
    bus.req_valid       = 1'b1;
    bus.req_address     = 32'h4000;
    bus.req_write_strobe = 4'b0000;
    init_sweep("reinit_cycles");
    step();
    bus.req_valid = 1'b0;
    chk("old_line_miss", 32'(bus.rsp_valid), 32'd0);
    wait_cmd("refill_0x4000", 1'b0, 32'h4000);
    fill(8'hD0, 1'b0);
    wait_rsp("rerd_0x4000", 32'hD0D0D0D0);

    // Three hits on the refilled line and one more clean miss
    issue(32'h4004, 4'b0000, 32'h0);
    chk("hit_0x4004", bus.rsp_data, 32'hD1D1D1D1);
    step();
    issue(32'h400C, 4'b0000, 32'h0);
    chk("hit_0x400c", bus.rsp_data, 32'hD3D3D3D3);
    step();
    issue(32'h4000, 4'b0000, 32'h0);
    chk("hit_0x4000", bus.rsp_data, 32'hD0D0D0D0);
    step();
    issue(32'h8000, 4'b0000, 32'h0);
    wait_cmd("fill_0x8000", 1'b0, 32'h8000);
    fill(8'hE0, 1'b0);
    wait_rsp("rd_0x8000", 32'hE0E0E0E0);

`ifdef CACHE_STATS_EN
    chk("stat_hits", stat_hits, 32'd3);
    chk("stat_misses", stat_misses, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
